// File: rtl/scandoubler_vidin_feeder.sv
// Scandoubler video-write feeder: packs the pixel stream into a 2x16-word ping-pong buffer
// and drains each full buffer as one 16-word burst. Optional SCANDOUBLER_VIDIN_FLUSH_EN zero-pads partial groups.
module scandoubler_vidin_feeder #(
    parameter int MAX_X = 1024,
    parameter int MAX_Y = 1024
) (
    input  logic        clk_96,
    input  logic        reset_n,
    input  logic        pix_ce,
    input  logic [15:0] pix_d,
    input  logic        pix_sol,
    input  logic        pix_sof,
    output logic        vidin_req,
    output logic        vidin_frame,
    output logic [9:0]  vidin_row,
    output logic [9:0]  vidin_col,
    output logic [15:0] vidin_d,
    input  logic        vidin_ack,
    output logic        wr_frame,
    output logic        overflow
);
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_XFER = 1'b1;
    localparam logic [10:0] MAX_X_C = 11'(MAX_X);
    localparam logic [10:0] MAX_Y_C = 11'(MAX_Y);

    // x/y carry one extra bit so they can saturate at 1024 without wrapping
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        wr_frame_q, wr_frame_d;
    logic        fill_sel_q, fill_sel_d;
    logic        overflow_q, overflow_d;

    logic [15:0] buf_q [2][16];
    logic [15:0] buf_d [2][16];
    logic [1:0]       full_q, full_d;
    logic [1:0][5:0]  tag_x_q, tag_x_d;
    logic [1:0][9:0]  tag_y_q, tag_y_d;
    logic [1:0]       tag_f_q, tag_f_d;

    logic [0:0]  state_q, state_d;
    logic [3:0]  rd_idx_q, rd_idx_d;
    logic        drain_sel_q, drain_sel_d;
    logic        req_q, req_d;
    logic [5:0]  cur_x_q, cur_x_d;
    logic [9:0]  cur_y_q, cur_y_d;
    logic        cur_f_q, cur_f_d;

    logic        flush_s;
    logic [10:0] eff_x_s;
    logic [10:0] eff_y_s;
    logic        sel_s;
    logic        store_en_s;
    logic        store_sel_s;
    logic [3:0]  store_idx_s;
    logic        set_full_s;
    logic        set_sel_s;
    logic [5:0]  set_x_s;
    logic [9:0]  set_y_s;
    logic        set_f_s;
    logic        free_s;

    // Fill side: position counters, line/frame markers, store and completion decisions
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        wr_frame_d  = wr_frame_q;
        fill_sel_d  = fill_sel_q;
        overflow_d  = overflow_q;
        flush_s     = 1'b0;
        eff_x_s     = x_q;
        eff_y_s     = y_q;
        sel_s       = fill_sel_q;
        store_en_s  = 1'b0;
        set_full_s  = 1'b0;
        set_sel_s   = fill_sel_q;
        set_x_s     = x_q[9:4];
        set_y_s     = y_q[9:0];
        set_f_s     = wr_frame_q;
        if (pix_ce) begin
            if (pix_sof || pix_sol) begin
`ifdef SCANDOUBLER_VIDIN_FLUSH_EN
                flush_s = (x_q[3:0] != 4'd0) && (x_q < MAX_X_C) && (y_q < MAX_Y_C) && !full_q[fill_sel_q];
`else
                flush_s = 1'b0;
`endif
                eff_x_s = 11'd0;
                if (pix_sof) begin
                    eff_y_s    = 11'd0;
                    wr_frame_d = ~wr_frame_q;
                end else if (y_q < MAX_Y_C) begin
                    eff_y_s = y_q + 11'd1;
                end else begin
                    eff_y_s = y_q;
                end
            end else begin
                eff_x_s = x_q;
                eff_y_s = y_q;
            end
            // a flushed partial group closes the current buffer; the new pixel goes to the other one
            if (flush_s) begin
                set_full_s = 1'b1;
                sel_s      = ~fill_sel_q;
            end else begin
                sel_s = fill_sel_q;
            end
            if ((eff_x_s < MAX_X_C) && (eff_y_s < MAX_Y_C)) begin
                x_d = eff_x_s + 11'd1;
                if (!full_q[sel_s]) begin
                    store_en_s = 1'b1;
                    if (eff_x_s[3:0] == 4'hF) begin
                        set_full_s = 1'b1;
                        set_sel_s  = sel_s;
                        set_x_s    = eff_x_s[9:4];
                        set_y_s    = eff_y_s[9:0];
                        set_f_s    = wr_frame_d;
                        fill_sel_d = ~sel_s;
                    end else begin
                        fill_sel_d = sel_s;
                    end
                end else begin
                    overflow_d = 1'b1;
                    fill_sel_d = sel_s;
                end
            end else begin
                x_d        = eff_x_s;
                fill_sel_d = sel_s;
            end
            y_d = eff_y_s;
        end else begin
            x_d = x_q;
        end
    end

    assign store_sel_s = sel_s;
    assign store_idx_s = eff_x_s[3:0];

    // Drain FSM: buffers fill alternately, so draining alternately keeps oldest-first order
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        drain_sel_d = drain_sel_q;
        req_d       = req_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_f_d     = cur_f_q;
        free_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[drain_sel_q]) begin
                    cur_x_d  = tag_x_q[drain_sel_q];
                    cur_y_d  = tag_y_q[drain_sel_q];
                    cur_f_d  = tag_f_q[drain_sel_q];
                    rd_idx_d = 4'd0;
                    req_d    = 1'b1;
                    state_d  = ST_XFER;
                end else begin
                    req_d = 1'b0;
                end
            end
            ST_XFER: begin
                if (vidin_ack) begin
                    if (rd_idx_q == 4'd15) begin
                        free_s      = 1'b1;
                        req_d       = 1'b0;
                        rd_idx_d    = 4'd0;
                        drain_sel_d = ~drain_sel_q;
                        state_d     = ST_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 4'd1;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Buffer storage: freeing clears a buffer so a later flushed group is already zero-padded
    always_comb begin
        buf_d   = buf_q;
        full_d  = full_q;
        tag_x_d = tag_x_q;
        tag_y_d = tag_y_q;
        tag_f_d = tag_f_q;
        if (free_s) begin
            full_d[drain_sel_q] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_d[drain_sel_q][4'(i)] = 16'h0000;
            end
        end else begin
            full_d = full_d;
        end
        if (store_en_s) begin
            buf_d[store_sel_s][store_idx_s] = pix_d;
        end else begin
            full_d = full_d;
        end
        if (set_full_s) begin
            full_d[set_sel_s]  = 1'b1;
            tag_x_d[set_sel_s] = set_x_s;
            tag_y_d[set_sel_s] = set_y_s;
            tag_f_d[set_sel_s] = set_f_s;
        end else begin
            full_d = full_d;
        end
    end

    // State registers
    always_ff @(posedge clk_96 or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= 11'd0;
            y_q         <= 11'd0;
            wr_frame_q  <= 1'b0;
            fill_sel_q  <= 1'b0;
            overflow_q  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[1'(b)][4'(i)] <= 16'h0000;
                end
            end
            full_q      <= 2'b00;
            tag_x_q     <= '0;
            tag_y_q     <= '0;
            tag_f_q     <= 2'b00;
            state_q     <= ST_IDLE;
            rd_idx_q    <= 4'd0;
            drain_sel_q <= 1'b0;
            req_q       <= 1'b0;
            cur_x_q     <= 6'd0;
            cur_y_q     <= 10'd0;
            cur_f_q     <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            wr_frame_q  <= wr_frame_d;
            fill_sel_q  <= fill_sel_d;
            overflow_q  <= overflow_d;
            buf_q       <= buf_d;
            full_q      <= full_d;
            tag_x_q     <= tag_x_d;
            tag_y_q     <= tag_y_d;
            tag_f_q     <= tag_f_d;
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            drain_sel_q <= drain_sel_d;
            req_q       <= req_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_f_q     <= cur_f_d;
        end
    end

    assign vidin_req   = req_q;
    assign vidin_frame = cur_f_q;
    assign vidin_row   = cur_y_q;
    assign vidin_col   = {cur_x_q, rd_idx_q};
    assign vidin_d     = buf_q[drain_sel_q][rd_idx_q];
    assign wr_frame    = wr_frame_q;
    assign overflow    = overflow_q;

endmodule
